// File: rtl/mux_nne1_regjistruar_if.sv
// Handshake bundle for mux_nne1_regjistruar.
//   master : the side that offers channel words and consumes the selected word
//   slave  : the multiplexer itself
// Signals:
//   hyrjet        N*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   sinjali       SELW     explicit channel select (modi=0)
//   modi          1        0 = direct select, 1 = round-robin pointer
//   in_valid      1        upstream word available
//   in_ready      1        multiplexer can accept this cycle
//   dalja         WIDTH    selected word at the head of the buffer
//   dalja_kanali  SELW     channel that produced dalja
//   gabim         1        head entry came from an out-of-range select
//   out_valid     1        dalja valid
//   out_ready     1        downstream accepts
//   dalja_paritet 1        even parity of dalja (only with MUX_NNE1_PARITY_EN)
interface mux_nne1_regjistruar_if #(
    parameter int WIDTH = 16,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] hyrjet;
    logic [SELW-1:0]    sinjali;
    logic               modi;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   dalja;
    logic [SELW-1:0]    dalja_kanali;
    logic               gabim;
    logic               out_valid;
    logic               out_ready;
`ifdef MUX_NNE1_PARITY_EN
    logic               dalja_paritet;
`endif

    modport master (
        output hyrjet, sinjali, modi, in_valid, out_ready,
`ifdef MUX_NNE1_PARITY_EN
        input  dalja_paritet,
`endif
        input  in_ready, dalja, dalja_kanali, gabim, out_valid
    );

    modport slave (
        input  hyrjet, sinjali, modi, in_valid, out_ready,
`ifdef MUX_NNE1_PARITY_EN
        output dalja_paritet,
`endif
        output in_ready, dalja, dalja_kanali, gabim, out_valid
    );
endinterface

// File: rtl/mux_nne1_regjistruar.sv
// N-to-1 registered operand multiplexer with a 2-entry skid buffer.
// A channel is chosen by explicit select (modi=0) or by an internal round-robin
// pointer (modi=1) and the word is queued behind valid/ready handshakes on both
// sides, sustaining one word per cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low
//   bus    mux_nne1_regjistruar_if.slave (see interface file for signal list)
// Optional build macro:
//   MUX_NNE1_PARITY_EN  adds bus.dalja_paritet = ^dalja, stored with each entry
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry held, out_valid=0, dalja=0
// ST_ONE   | head entry valid, skid slot free
// ST_FULL  | head and skid both held, in_ready=0
module mux_nne1_regjistruar #(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mux_nne1_regjistruar_if.slave   bus
);
    localparam int SELW = $clog2(N);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  kan;
        logic             gab;
`ifdef MUX_NNE1_PARITY_EN
        logic             par;
`endif
    } entry_t;

    state_t          state, state_n;
    entry_t          head, head_n;
    entry_t          skid, skid_n;
    entry_t          new_e;
    logic [SELW-1:0] ptr, ptr_n;
    logic [SELW-1:0] sel;
    logic            rdy, rdy_n;
    logic            vld, vld_n;
    logic            found;
    logic            in_xfer;
    logic            out_xfer;

    // Build the incoming entry. An out-of-range select matches no channel,
    // so the word stays 0 rather than X and the entry is flagged.
    always_comb begin
        new_e = '0;
        found = 1'b0;
        sel   = bus.modi ? ptr : bus.sinjali;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                new_e.data = bus.hyrjet[k*WIDTH +: WIDTH];
                found      = 1'b1;
            end
        end
        new_e.kan = sel;
        new_e.gab = ~found;
`ifdef MUX_NNE1_PARITY_EN
        new_e.par = ^new_e.data;
`endif
    end

    assign in_xfer  = bus.in_valid & rdy;
    assign out_xfer = vld & bus.out_ready;

    always_comb begin
        state_n = state;
        head_n  = head;
        skid_n  = skid;
        ptr_n   = ptr;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    head_n  = new_e;
                    state_n = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    head_n = new_e;
                end else if (in_xfer) begin
                    skid_n  = new_e;
                    state_n = ST_FULL;
                end else if (out_xfer) begin
                    head_n  = '0;
                    state_n = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (out_xfer) begin
                    head_n  = skid;
                    state_n = ST_ONE;
                end
            end
            default: begin
                head_n  = '0;
                state_n = ST_EMPTY;
            end
        endcase
        if (in_xfer && bus.modi) begin
            ptr_n = (ptr == SELW'(N - 1)) ? '0 : ptr + SELW'(1);
        end
        // Ready and valid are registered copies of the next occupancy so no
        // combinational path exists from out_ready to in_ready.
        rdy_n = (state_n != ST_FULL);
        vld_n = (state_n != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            head  <= '0;
            skid  <= '0;
            ptr   <= '0;
            rdy   <= 1'b0;
            vld   <= 1'b0;
        end else begin
            state <= state_n;
            head  <= head_n;
            skid  <= skid_n;
            ptr   <= ptr_n;
            rdy   <= rdy_n;
            vld   <= vld_n;
        end
    end

    assign bus.in_ready     = rdy;
    assign bus.out_valid    = vld;
    assign bus.dalja        = head.data;
    assign bus.dalja_kanali = head.kan;
    assign bus.gabim        = head.gab;
`ifdef MUX_NNE1_PARITY_EN
    assign bus.dalja_paritet = head.par;
`endif

endmodule
